rr_chan_mux: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with per-channel valid/ready handshakes and a registered, back-pressurable output stage. It generalises the fixed 8:1 × 4-bit select mux to any channel count and width. It adds a round-robin scan mode alongside fixed select. It sits between a bank of channel producers and a single downstream consumer in the datapath.

---
 rtl/rr_chan_mux_pkg.sv | 17 +
 rtl/rr_chan_mux_pick.sv | 39 +++
 rtl/rr_chan_mux.sv | 88 ++++++++
 tb/tb_rr_chan_mux.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rr_chan_mux_pkg.sv
// Shared mode encodings and small index helpers for rr_chan_mux and its bench.
package rr_chan_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Next index after i in a ring of n entries.
  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

  // Index reached by stepping off positions forward from base in a ring of n.
  function automatic int wrap_add(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/rr_chan_mux_pick.sv
// Round-robin search: rotate V so ptr sits at bit 0, priority-encode, unrotate.
module rr_pick
  import rr_chan_mux_pkg::*;
#(
  parameter  int N  = 8,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  v,
  input  logic [SW-1:0] ptr,
  output logic          found,
  output logic [SW-1:0] idx
);

  logic [N-1:0]  rot;
  logic [SW-1:0] off;

  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++)
      rot[i] = v[wrap_add(int'(ptr), i, N)];
  end

  // Lowest set bit of the rotated vector is the nearest request at or after ptr.
  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = SW'(i);
      end
    end
  end

  always_comb begin
    idx = SW'(wrap_add(int'(ptr), int'(off), N));
  end

endmodule

// File: rtl/rr_chan_mux.sv
// N-channel, W-bit registered mux with fixed-select or round-robin arbitration
// and a single back-pressurable output register.
module rr_chan_mux
  import rr_chan_mux_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int W  = 4,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [N*W-1:0] D,
  input  logic [N-1:0]  V,
  output logic [N-1:0]  R,
  input  logic          MODE,
  input  logic [SW-1:0] S,
  output logic [W-1:0]  O,
  output logic          OV,
  input  logic          OR,
  output logic [SW-1:0] OS
);

  logic          ld;
  logic          has;
  logic          s_v;
  logic          rr_found;
  logic [SW-1:0] rr_idx;
  logic [SW-1:0] c;
  logic [SW-1:0] ptr;
  logic [W-1:0]  dsel;

  rr_pick #(.N(N)) u_pick (
    .v     (V),
    .ptr   (ptr),
    .found (rr_found),
    .idx   (rr_idx)
  );

  assign ld = !OV || OR;

  // An out-of-range S matches no channel, so it qualifies as "no candidate".
  always_comb begin
    s_v = 1'b0;
    for (int i = 0; i < N; i++)
      if (S == SW'(i)) s_v = V[i];
  end

  always_comb begin
    if (MODE == MODE_RR) begin
      has = rr_found;
      c   = rr_idx;
    end else begin
      has = s_v;
      c   = S;
    end
  end

  always_comb begin
    R = '0;
    for (int i = 0; i < N; i++)
      R[i] = RST_N && ld && has && (c == SW'(i));
  end

  always_comb begin
    dsel = '0;
    for (int i = 0; i < N; i++)
      if (c == SW'(i)) dsel = D[i*W +: W];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      O   <= '0;
      OS  <= '0;
      OV  <= 1'b0;
      ptr <= '0;
    end else if (ld) begin
      if (has) begin
        O   <= dsel;
        OS  <= c;
        OV  <= 1'b1;
        ptr <= SW'(wrap_inc(int'(c), N));
      end else begin
        OV  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_chan_mux.sv
// Self-checking bench for rr_chan_mux: vector table, corner sequences, random vs model.
module tb_rr_chan_mux;
  import rr_chan_mux_pkg::*;

  localparam int N = 8;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] d;
  logic [N-1:0]   v, r;
  logic           mode, ov, orr;
  logic [2:0]     s, os;
  logic [W-1:0]   o;

  // Second instance with a non-power-of-two channel count.
  logic [6*W-1:0] d6;
  logic [5:0]     v6, r6;
  logic           mode6, ov6, orr6;
  logic [2:0]     s6, os6;
  logic [W-1:0]   o6;

  int errs = 0;
  int checks = 0;

  // Reference model state
  int          m_ptr;
  logic [3:0]  m_o;
  int          m_os;
  logic        m_ov;

  always #5 clk = ~clk;

  rr_chan_mux #(.N(N), .W(W)) dut (
    .CLK(clk), .RST_N(rst_n), .D(d), .V(v), .R(r), .MODE(mode), .S(s),
    .O(o), .OV(ov), .OR(orr), .OS(os)
  );

  rr_chan_mux #(.N(6), .W(W)) dut6 (
    .CLK(clk), .RST_N(rst_n), .D(d6), .V(v6), .R(r6), .MODE(mode6), .S(s6),
    .O(o6), .OV(ov6), .OR(orr6), .OS(os6)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_o = '0; m_os = 0; m_ov = 1'b0;
  endtask

  // Called after posedge with inputs already driven; returns R sampled at negedge.
  task automatic tick(output logic [7:0] r_seen);
    bit ld, has;
    int c;
    logic [7:0] exp_r;
    ld = !m_ov || orr;
    has = 0;
    c = 0;
    if (mode == MODE_FIXED) begin
      if (int'(s) < N && v[s]) begin has = 1; c = int'(s); end
    end else begin
      for (int k = 0; k < N; k++)
        if (!has && v[(m_ptr + k) % N]) begin has = 1; c = (m_ptr + k) % N; end
    end
    exp_r = (ld && has) ? (8'd1 << c) : 8'd0;
    @(negedge clk);
    r_seen = r;
    chk("model_r", r, exp_r);
    @(posedge clk);
    if (ld) begin
      if (has) begin
        m_o = d[c*W +: W]; m_os = c; m_ov = 1'b1; m_ptr = (c + 1) % N;
      end else begin
        m_ov = 1'b0;
      end
    end
    #1;
    chk("model_ov", ov, m_ov);
    chk("model_o", o, m_o);
    chk("model_os", os, m_os);
  endtask

  typedef struct {
    logic       mode;
    logic [2:0] s;
    logic [7:0] v;
    logic       orr;
    logic [7:0] r;
    logic [3:0] o;
    logic [2:0] os;
    logic       ov;
  } vec_t;

  vec_t tbl[12];
  logic [7:0] rs;

  initial begin
    // mode, s, v, or -> R, O, OS, OV (after the edge)
    tbl[0]  = '{MODE_FIXED, 3'd5, 8'hFF, 1'b1, 8'h20, 4'h6, 3'd5, 1'b1};
    tbl[1]  = '{MODE_FIXED, 3'd5, 8'hFF, 1'b1, 8'h20, 4'h6, 3'd5, 1'b1};
    tbl[2]  = '{MODE_FIXED, 3'd2, 8'hFF, 1'b1, 8'h04, 4'h3, 3'd2, 1'b1};
    tbl[3]  = '{MODE_RR,    3'd0, 8'hFF, 1'b1, 8'h08, 4'h4, 3'd3, 1'b1};
    tbl[4]  = '{MODE_RR,    3'd0, 8'h82, 1'b1, 8'h80, 4'h8, 3'd7, 1'b1};
    tbl[5]  = '{MODE_RR,    3'd0, 8'h82, 1'b1, 8'h02, 4'h2, 3'd1, 1'b1};
    tbl[6]  = '{MODE_RR,    3'd0, 8'h82, 1'b1, 8'h80, 4'h8, 3'd7, 1'b1};
    tbl[7]  = '{MODE_RR,    3'd0, 8'h00, 1'b1, 8'h00, 4'h8, 3'd7, 1'b0};
    tbl[8]  = '{MODE_FIXED, 3'd3, 8'hF7, 1'b1, 8'h00, 4'h8, 3'd7, 1'b0};
    tbl[9]  = '{MODE_FIXED, 3'd3, 8'h08, 1'b0, 8'h08, 4'h4, 3'd3, 1'b1};
    tbl[10] = '{MODE_RR,    3'd0, 8'hFF, 1'b0, 8'h00, 4'h4, 3'd3, 1'b1};
    tbl[11] = '{MODE_RR,    3'd0, 8'hFF, 1'b1, 8'h10, 4'h5, 3'd4, 1'b1};

    rst_n = 1'b0;
    d = 32'h8765_4321; v = '0; mode = MODE_FIXED; s = '0; orr = 1'b1;
    d6 = 24'h65_4321; v6 = '0; mode6 = MODE_FIXED; s6 = '0; orr6 = 1'b1;
    #3;
    chk("rst_o", o, 0); chk("rst_os", os, 0); chk("rst_ov", ov, 0); chk("rst_r", r, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 12; i++) begin
      mode = tbl[i].mode; s = tbl[i].s; v = tbl[i].v; orr = tbl[i].orr;
      tick(rs);
      chk($sformatf("tbl%0d_r", i), rs, tbl[i].r);
      chk($sformatf("tbl%0d_o", i), o, tbl[i].o);
      chk($sformatf("tbl%0d_os", i), os, tbl[i].os);
      chk($sformatf("tbl%0d_ov", i), ov, tbl[i].ov);
    end

    // Asynchronous reset mid-stream with OV=1, checked without a clock edge.
    rst_n = 1'b0;
    #1;
    chk("amid_o", o, 0); chk("amid_os", os, 0); chk("amid_ov", ov, 0); chk("amid_r", r, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    model_reset();

    // Round-robin, all valid: wraps 7 -> 0 without a gap.
    mode = MODE_RR; v = 8'hFF; orr = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick(rs);
      chk($sformatf("rr_os%0d", i), os, i % 8);
      chk($sformatf("rr_o%0d", i), o, (i % 8) + 1);
    end

    // Backpressure while holding channel 2's word.
    tick(rs);
    tick(rs);
    chk("bp_pre_os", os, 2);
    orr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(rs);
      chk($sformatf("bp_r%0d", i), rs, 0);
      chk($sformatf("bp_o%0d", i), o, 3);
      chk($sformatf("bp_os%0d", i), os, 2);
    end
    orr = 1'b1;
    tick(rs);
    chk("bp_post_os", os, 3);
    chk("bp_post_o", o, 4);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      mode = 1'($urandom);
      s    = 3'($urandom);
      v    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom & $urandom);
      orr  = ($urandom_range(0, 3) != 0);
      d    = $urandom;
      tick(rs);
    end

    // N=6 instance: in-range select works, out-of-range select gives nothing.
    mode6 = MODE_FIXED; s6 = 3'd5; v6 = 6'h3F; orr6 = 1'b1;
    #1;
    chk("n6_r_ok", r6, 6'h20);
    @(posedge clk); #1;
    chk("n6_o_ok", o6, 4'h6);
    chk("n6_ov_ok", ov6, 1);
    s6 = 3'd7;
    #1;
    chk("n6_r_oor", r6, 0);
    @(posedge clk); #1;
    chk("n6_ov_oor", ov6, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
